rca_chunk_sequencer: RTL and testbench
======================================

// Module: rca_chunk_sequencer
// PURPOSE
//   Multi-cycle wide adder built on one shared 4-bit ripple-carry slice.
//   Accepts WIDTH-bit operands over a valid/ready handshake and sequences the slice one nibble per cycle, LSB first.
//   A registered carry links the chunks; sum, carry-out and signed overflow are returned over a valid/ready handshake.
//   Sits between operand producers and result consumers wherever area matters more than add latency.
// PARAMETERS
//   WIDTH   16   operand/sum width in bits; must be a multiple of 4 and >= 8
//   CHUNKS  WIDTH/4   derived localparam; number of slice passes
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands A, B, C0 valid
//   in_ready   out  1      block can accept operands
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   C0         in   1      carry-in to bit 0
//   out_valid  out  1      S, C_OUT, OVF valid
//   out_ready  in   1      consumer takes result
//   S          out  WIDTH  sum
//   C_OUT      out  1      carry out of MSB
//   OVF        out  1      two's-complement overflow (carry into MSB xor C_OUT)
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   - FSM states: IDLE, RUN, DONE (encoded in 2 bits).
//   - Reset: state=IDLE; in_ready=1; out_valid=0; S=0; C_OUT=0; OVF=0; busy=0; chunk counter=0; carry reg=0.
//   - IDLE: in_ready=1. On in_valid&&in_ready, capture A, B, C0 into operand shift regs and the carry reg. Clear the counter and go to RUN.
//   - RUN: in_ready=0. Each edge adds A_reg[3:0]+B_reg[3:0]+carry through the slice.
//     Shift A_reg/B_reg right by 4; shift the slice sum into S_reg from the MSB side; carry <= slice carry-out; counter++.
//   - Last chunk (counter==CHUNKS-1): also latch the slice's carry into bit 3 (internal C3) for OVF. Go to DONE.
//   - DONE: out_valid=1. S/C_OUT/OVF are held stable while out_ready=0.
//     On out_ready go to IDLE; in_ready rises the following cycle. No same-cycle accept out of DONE.
//   - Latency: out_valid is first high after CHUNKS+1 rising edges, counting the accepting edge (5 for WIDTH=16).
//     Throughput: one add per CHUNKS+2 cycles with out_ready held high.
//   - in_valid while in RUN/DONE is ignored; the input values are not sampled.
//   - out_ready in IDLE/RUN is ignored.
//   - S, C_OUT and OVF keep their last result after leaving DONE until the next RUN overwrites them. They are only meaningful while out_valid=1.
//   - Arithmetic: modulo 2^WIDTH; the full WIDTH+1 result is {C_OUT,S}.
//     Intermediate carries never leave the block.
//   - rst asserted in any state, including mid-RUN: the operation is aborted, all reset values apply on the next edge, and no result is emitted.
//   - The counter wraps to 0 only via the IDLE->RUN transition; it never exceeds CHUNKS-1.
// STRUCTURE
//   - Shared package rca_pkg: state typedef (IDLE/RUN/DONE), SLICE_W=4 constant, and a width-check function that flags WIDTH%4!=0.
//   - One sub-module: rca4_slice (4-bit ripple-carry adder: A,B,C0 -> S,C4, plus C3 exposed for overflow).
//     It is built from four full-adder cells, is purely combinational, and is instantiated once.
//   - Top holds the FSM, counter, operand/sum shift regs, carry reg and the handshakes.
// TESTING (WIDTH=16)
//   - A=0x1234,B=0x4321,C0=0 -> S=0x5555,C_OUT=0,OVF=0. out_valid is first high 5 edges after accept.
//   - A=0xFFFF,B=0x0001,C0=0 -> S=0x0000,C_OUT=1,OVF=0 (carry propagates through all 4 chunks).
//   - A=0x7FFF,B=0x0000,C0=1 -> S=0x8000,C_OUT=0,OVF=1; A=0x8000,B=0x8000 -> S=0x0000,C_OUT=1,OVF=1.
//   - Hold out_ready=0 for 3 cycles in DONE -> out_valid, S, C_OUT stay stable. in_valid pulses during RUN/DONE are not accepted; in_ready stays 0.
//   - Assert rst on the 2nd RUN edge -> next cycle IDLE, out_valid=0, S=0, in_ready=1. A fresh A=0x0001,B=0x0001 then yields S=0x0002.
//   - Back-to-back: out_ready tied 1 with continuous in_valid -> accepts are spaced CHUNKS+2=6 cycles apart. Results come in order with no lost transaction.

Source files
------------

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared types and constants for the chunked ripple-carry adder
package rca_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand width must split evenly into slices and span at least two of them.
  function automatic bit width_ok(input int w);
    return ((w % SLICE_W) == 0) && (w >= 2 * SLICE_W);
  endfunction

endpackage

// File: rtl/rca4_slice.sv
// rtl/rca4_slice.sv - 4-bit ripple-carry slice of four full-adder cells
// c3 is the carry into the slice MSB, used by the parent for signed overflow.
module rca4_slice
  import rca_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               c3,
  output logic               c4
);

  logic [SLICE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c3 = c[SLICE_W-1];
  assign c4 = c[SLICE_W];

endmodule

// File: rtl/rca_chunk_sequencer.sv
// rtl/rca_chunk_sequencer.sv - multi-cycle wide adder sequencing one shared 4-bit slice
// Operands are consumed LSB nibble first; the sum is assembled from the MSB side of S.
module rca_chunk_sequencer
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_OUT,
  output logic             OVF,
  output logic             busy
);

  localparam int CHUNKS = WIDTH / SLICE_W;
  localparam int CNT_W  = $clog2(CHUNKS);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_c3;
  logic               slice_c4;

  rca4_slice u_slice (
    .a  (a_reg[SLICE_W-1:0]),
    .b  (b_reg[SLICE_W-1:0]),
    .ci (carry),
    .s  (slice_s),
    .c3 (slice_c3),
    .c4 (slice_c4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (width_ok(WIDTH));
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      S         <= '0;
      C_OUT     <= 1'b0;
      OVF       <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            carry    <= C0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
          a_reg <= a_reg >> SLICE_W;
          b_reg <= b_reg >> SLICE_W;
          S     <= {slice_s, S[WIDTH-1:SLICE_W]};
          carry <= slice_c4;
          // Counter parks at the last chunk; only the accept edge rewinds it.
          if (cnt == LAST_CHUNK) begin
            C_OUT     <= slice_c4;
            OVF       <= slice_c3 ^ slice_c4;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_chunk_sequencer.sv
// tb/tb_rca_chunk_sequencer.sv - scoreboard bench for the chunked ripple-carry adder
module tb_rca_chunk_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        c_out;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t exp_q[$];

  rca_chunk_sequencer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .C0        (c0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s),
    .C_OUT     (c_out),
    .OVF       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every completed output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got S=0x%0h with no pending transaction", s);
      end else begin
        e = exp_q.pop_front();
        check("result_S", {16'd0, s}, {16'd0, e.s});
        check("result_C_OUT", {31'd0, c_out}, {31'd0, e.c});
        check("result_OVF", {31'd0, ovf}, {31'd0, e.o});
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      input logic push, input logic [15:0] es, input logic ec,
                      input logic eo, output int acc_cyc);
    int w;
    exp_t e;
    in_valid = 1'b1;
    a  = ta;
    b  = tb_v;
    c0 = tc;
    w  = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1 within 50 cycles", in_ready);
      acc_cyc = -1;
      in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.o = eo;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c0;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  initial begin
    int k;
    int acc;
    int prev_acc;
    int w;
    vec_t vecs[6];

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    c0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_S", {16'd0, s}, 32'd0);
    check("reset_C_OUT", {31'd0, c_out}, 32'd0);
    check("reset_OVF", {31'd0, ovf}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Latency, ignored in_valid during RUN/DONE, and output hold under backpressure.
    send(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, acc);
    in_valid = 1'b1;
    a = 16'hDEAD;
    b = 16'hBEEF;
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      check("run_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("run_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      k++;
    end
    check("latency_edges", k, 32'd5);
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_S", {16'd0, s}, 32'h5555);
      check("hold_C_OUT", {31'd0, c_out}, 32'd0);
      check("hold_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("after_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("after_done_in_ready", {31'd0, in_ready}, 32'd1);

    // Abort mid-RUN: rst sampled on the second RUN edge, no result emitted.
    @(posedge clk);
    #1;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_S", {16'd0, s}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, acc);

    // Back-to-back with out_ready held high: accepts spaced CHUNKS+2 cycles.
    prev_acc = -1;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].c0, 1'b1, vecs[i].s, vecs[i].c, vecs[i].o, acc);
      if (prev_acc >= 0 && acc >= 0 && i > 1)
        check("b2b_spacing", acc - prev_acc, 32'd6);
      prev_acc = acc;
    end

    w = 0;
    while (exp_q.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
